data_req_ctrl: RTL

DATA_REQ_CTRL -- requirements
Module: data_req_ctrl

---
 rtl/data_req_ctrl.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/data_req_ctrl.sv
// data_req_ctrl: MEM-stage controller for an SRAM-like data bus.
// It issues one load/store request at a time, holds the pipeline while a
// request is outstanding, buffers load data when WB cannot take it yet, and
// drops the response of an instruction that was flushed mid-transaction.
// Optional feature: define UNALIGNED_EXC_EN to raise adel/ades on misaligned
// half/word accesses instead of silently aligning the bus address.

// Opcodes normally come from the shared OP_* defines; these are fallbacks used
// only when that header has not been included ahead of this file.
`ifndef OP_LB
`define OP_LB  6'b100000
`endif
`ifndef OP_LH
`define OP_LH  6'b100001
`endif
`ifndef OP_LW
`define OP_LW  6'b100011
`endif
`ifndef OP_LBU
`define OP_LBU 6'b100100
`endif
`ifndef OP_LHU
`define OP_LHU 6'b100101
`endif
`ifndef OP_SB
`define OP_SB  6'b101000
`endif
`ifndef OP_SH
`define OP_SH  6'b101001
`endif
`ifndef OP_SW
`define OP_SW  6'b101011
`endif

module data_req_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] instr_M,
  input  logic [31:0] alu_out_M,
  input  logic [31:0] write_data_M,
  input  logic        allowin_W,
  input  logic        flush,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] word_data,
  output logic        stall_M,
  output logic        adel,
  output logic        ades,
  output logic [31:0] bad_addr
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state_q, state_d;
  logic        cancel_q, cancel_d;
  logic [31:0] word_q;

  // Request fields captured at issue so they stay stable while in REQ.
  logic        req_wr_q;
  logic [1:0]  req_size_q;
  logic [31:0] req_addr_q, req_wdata_q;
  logic [3:0]  req_wstrb_q;

  logic [5:0]  opcode;
  logic        is_load, is_store, memop, misaligned;
  logic        start, kill, complete, issue, accept;
  logic [1:0]  size_c;
  logic [31:0] addr_c, wdata_c;
  logic [3:0]  wstrb_c;
  logic        unused_instr;

  assign opcode       = instr_M[31:26];
  assign unused_instr = ^instr_M[25:0];

  // Opcode decode into load/store class and access size.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    is_load  = 1'b0;
    is_store = 1'b0;
    size_c   = 2'd0;
    case (opcode)
      `OP_LB, `OP_LBU: begin is_load  = 1'b1; size_c = 2'd0; end
      `OP_LH, `OP_LHU: begin is_load  = 1'b1; size_c = 2'd1; end
      `OP_LW:          begin is_load  = 1'b1; size_c = 2'd2; end
      `OP_SB:          begin is_store = 1'b1; size_c = 2'd0; end
      `OP_SH:          begin is_store = 1'b1; size_c = 2'd1; end
      `OP_SW:          begin is_store = 1'b1; size_c = 2'd2; end
      default: ;
    endcase
  end

  assign memop = is_load | is_store;

`ifdef UNALIGNED_EXC_EN
  assign misaligned = memop && ((size_c == 2'd1 && alu_out_M[0]) ||
                                (size_c == 2'd2 && alu_out_M[1:0] != 2'b00));
  assign addr_c     = alu_out_M;
  assign adel       = resetn && state_q == IDLE && mem_valid && !flush && is_load  && misaligned;
  assign ades       = resetn && state_q == IDLE && mem_valid && !flush && is_store && misaligned;
  assign bad_addr   = alu_out_M;
`else
  assign misaligned = 1'b0;
  assign adel       = 1'b0;
  assign ades       = 1'b0;
  assign bad_addr   = 32'h0;

  // Without the exception path, force half/word accesses onto their natural boundary.
  always_comb begin
    addr_c = alu_out_M;
    case (size_c)
      2'd1:    addr_c[0]   = 1'b0;
      2'd2:    addr_c[1:0] = 2'b00;
      default: ;
    endcase
  end
`endif

  // Store lane replication and byte enables; loads drive no strobes.
  always_comb begin
    wdata_c = write_data_M;
    wstrb_c = 4'b1111;
    case (size_c)
      2'd0: begin
        wdata_c = {4{write_data_M[7:0]}};
        wstrb_c = 4'b0001 << addr_c[1:0];
      end
      2'd1: begin
        wdata_c = {2{write_data_M[15:0]}};
        wstrb_c = 4'b0011 << addr_c[1:0];
      end
      default: ;
    endcase
    if (!is_store) wstrb_c = 4'b0000;
  end

  assign start = resetn && state_q == IDLE && mem_valid && memop && !flush && !misaligned;
  assign kill  = cancel_q | flush;

  // Next-state, handshake and stall decisions for the single outstanding request.
  always_comb begin
    state_d  = state_q;
    cancel_d = cancel_q;
    issue    = 1'b0;
    complete = 1'b0;
    stall_M  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          issue = 1'b1;
          if (data_addr_ok && data_data_ok) complete = 1'b1;
          else if (data_addr_ok)            state_d  = WAIT;
          else                              state_d  = REQ;
          stall_M = !complete;
        end
      end
      REQ: begin
        issue = 1'b1;
        if (data_addr_ok && data_data_ok) complete = 1'b1;
        else if (data_addr_ok)            state_d  = WAIT;
        stall_M = !complete && !kill;
        if (flush) cancel_d = 1'b1;
      end
      WAIT: begin
        complete = data_data_ok;
        stall_M  = !complete && !kill;
        if (flush) cancel_d = 1'b1;
      end
      HOLD: begin
        if (flush || allowin_W) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A killed response is dropped and the controller simply returns to IDLE.
    if (complete) begin
      state_d  = (kill || allowin_W) ? IDLE : HOLD;
      cancel_d = 1'b0;
    end
  end

  assign accept    = complete && !kill;
  assign word_data = accept ? data_rdata : word_q;

  // State, cancel flag and buffered load word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cancel_q <= 1'b0;
      word_q   <= 32'h0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      cancel_q <= cancel_d;
      if (accept) word_q <= data_rdata;
    end
  end

  // Capture the request fields on the cycle the request first issues.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_wr_q    <= 1'b0;
      req_size_q  <= 2'd0;
      req_addr_q  <= 32'h0;
      req_wdata_q <= 32'h0;
      req_wstrb_q <= 4'b0000;
    end else if (start) begin
      req_wr_q    <= is_store;
      req_size_q  <= size_c;
      req_addr_q  <= addr_c;
      req_wdata_q <= wdata_c;
      req_wstrb_q <= wstrb_c;
    end
  end

  assign data_req   = issue;
  assign data_wr    = (state_q == IDLE) ? is_store : req_wr_q;
  assign data_size  = (state_q == IDLE) ? size_c   : req_size_q;
  assign data_addr  = (state_q == IDLE) ? addr_c   : req_addr_q;
  assign data_wdata = (state_q == IDLE) ? wdata_c  : req_wdata_q;
  assign data_wstrb = (state_q == IDLE) ? wstrb_c  : req_wstrb_q;

endmodule
